sp_ram_ctrl: RTL and testbench

SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

---
 rtl/sp_ram_ctrl_pkg.sv | 40 ++++
 rtl/sp_ram_ctrl_obuf.sv | 87 ++++++++
 rtl/sp_ram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sp_ram_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl_pkg
// Shared types for the single-port RAM controller:
//   state_e : controller FSM state (INIT clears the RAM, RUN serves requests)
//   gnt_e   : which request channel owns the RAM port in the current cycle
//   grant_rr: round-robin arbitration helper between the write and read
//             channels
// ---------------------------------------------------------------------------
package sp_ram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  // Picks the channel that owns the RAM this cycle. When both channels can go,
  // the one that did not win the last grant takes it, so a flag that starts
  // out as "read" hands the first conflict to the write channel.
  function automatic gnt_e grant_rr(input logic wr_ok,
                                    input logic rd_ok,
                                    input logic last_was_rd);
    gnt_e g;
    g = GNT_NONE;
    if (wr_ok && rd_ok) begin
      g = last_was_rd ? GNT_WR : GNT_RD;
    end else if (wr_ok) begin
      g = GNT_WR;
    end else if (rd_ok) begin
      g = GNT_RD;
    end
    return g;
  endfunction

endpackage

// File: rtl/sp_ram_ctrl_obuf.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl_obuf
// Synchronous response FIFO holding read data on its way to the response
// channel. DEPTH must be a power of two so the pointers wrap for free.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   push_i       : write push_data_i into the tail this cycle
//   push_data_i  : data to enqueue
//   pop_i        : drop the head entry this cycle
//   pop_data_o   : head entry (valid whenever empty_o is low)
//   count_o      : number of stored entries, 0..DEPTH
//   empty_o      : no entries stored
// ---------------------------------------------------------------------------
module sp_ram_ctrl_obuf
  import sp_ram_ctrl_pkg::*;
#(
  parameter int DW    = 18,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pushes into a full buffer and pops from an empty one are ignored so a
  // misbehaving caller cannot corrupt the pointers; the controller's credit
  // check keeps the push side from ever needing this.
  always_comb begin
    do_push  = push_i && (count_q != CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // A push and pop together leave the occupancy where it was.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
// Front end for an external single-port RAM with a fixed read latency.
// After reset it optionally zero-fills the whole RAM, then arbitrates between
// a write channel and a read channel (round robin on conflict), tracks reads
// in flight and returns read data, in order, through a response FIFO.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data  : write request channel
//   rd_valid/rd_ready/rd_addr          : read request channel
//   rsp_valid/rsp_ready/rsp_data       : read response channel
//   ram_we/ram_addr/ram_din/ram_dout   : RAM port; ram_dout is valid
//                                        RD_LATENCY cycles after the address
//   init_done                          : controller is serving requests
// ---------------------------------------------------------------------------
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 18,
  parameter int RD_LATENCY = 1,
  parameter int OBUF_DEPTH = 4,
  parameter bit INIT_CLEAR = 1'b1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          init_done
);

  localparam int CW    = $clog2(OBUF_DEPTH) + 1;
  localparam int CNT_W = CW + 1;

  state_e                state_q, state_d;
  logic [AW-1:0]         init_cnt_q, init_cnt_d;
  logic                  last_rd_q, last_rd_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  gnt_e                  gnt;
  logic [CW-1:0]         obuf_count;
  logic                  obuf_empty;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      committed;
  logic                  rd_ok;
  logic                  obuf_push;
  logic                  obuf_pop;

  // Every read in flight or sitting in the buffer holds a buffer slot, so a
  // new read is only admitted while a free slot remains. This is what keeps
  // the response FIFO from overflowing when rsp_ready is held low.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(rd_pipe_q[i]);
    end
    committed = inflight + CNT_W'(obuf_count);
    rd_ok     = rd_valid && (committed < CNT_W'(OBUF_DEPTH));
  end

  // Next-state and RAM-port decision. At most one RAM operation issues per
  // cycle and the RAM port is driven straight from that decision. Everything
  // is forced idle while rst_n is low so the RAM sees no write during reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    last_rd_d  = last_rd_q;
    gnt        = GNT_NONE;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    if (rst_n) begin
      case (state_q)
        INIT: begin
          ram_we     = 1'b1;
          ram_addr   = init_cnt_q;
          init_cnt_d = init_cnt_q + AW'(1);
          if (init_cnt_q == '1) begin
            state_d = RUN;
          end
        end
        RUN: begin
          gnt = grant_rr(wr_valid, rd_ok, last_rd_q);
          case (gnt)
            GNT_WR: begin
              ram_we    = 1'b1;
              ram_addr  = wr_addr;
              ram_din   = wr_data;
              last_rd_d = 1'b0;
            end
            GNT_RD: begin
              ram_addr  = rd_addr;
              last_rd_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = RUN;
      endcase
    end
  end

  // The in-flight shift register marks which cycles carry read data on
  // ram_dout: a bit enters when a read issues and reaches the last stage in
  // the cycle the RAM presents that read's data.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = (gnt == GNT_RD);
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  // Controller state registers. Reset starts the clear sweep from address 0
  // (or goes straight to RUN when clearing is disabled), drops all reads in
  // flight and makes the next arbitration conflict favour the write channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_CLEAR ? INIT : RUN;
      init_cnt_q <= '0;
      last_rd_q  <= 1'b1;
      rd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      last_rd_q  <= last_rd_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  assign obuf_push = rd_pipe_q[RD_LATENCY-1];
  assign obuf_pop  = rsp_valid && rsp_ready;

  sp_ram_ctrl_obuf #(
    .DW    (DW),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (obuf_push),
    .push_data_i (ram_dout),
    .pop_i       (obuf_pop),
    .pop_data_o  (rsp_data),
    .count_o     (obuf_count),
    .empty_o     (obuf_empty)
  );

  assign rsp_valid = !obuf_empty;
  assign wr_ready  = (gnt == GNT_WR);
  assign rd_ready  = (gnt == GNT_RD);
  assign init_done = rst_n && (state_q == RUN);

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_ctrl
// Self-checking bench for sp_ram_ctrl with AW=5, RD_LATENCY=2, OBUF_DEPTH=4,
// INIT_CLEAR=1. Includes a behavioural single-port RAM with a two-cycle read
// pipeline. Expected read data is queued when a read is accepted and a
// separate monitor process compares each response as it is handed over.
// ---------------------------------------------------------------------------
module tb_sp_ram_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 18;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rstN;
  logic          wrValid;
  logic          wrReady;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          rdValid;
  logic          rdReady;
  logic [AW-1:0] rdAddr;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspData;
  logic          ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDin;
  logic [DW-1:0] ramDout;
  logic          initDone;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] refMem [NADDR];
  logic [DW-1:0] expQ [$];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  sp_ram_ctrl #(
    .AW         (AW),
    .DW         (DW),
    .RD_LATENCY (LAT),
    .OBUF_DEPTH (DEPTH),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .wr_valid  (wrValid),
    .wr_ready  (wrReady),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .rd_valid  (rdValid),
    .rd_ready  (rdReady),
    .rd_addr   (rdAddr),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_data  (rspData),
    .ram_we    (ramWe),
    .ram_addr  (ramAddr),
    .ram_din   (ramDin),
    .ram_dout  (ramDout),
    .init_done (initDone)
  );

  // Behavioural RAM: filled with non-zero junk on the first edge so the clear
  // sweep is observable, then written on ram_we and read through a LAT-stage
  // output pipeline.
  logic          seeded = 1'b0;
  logic [DW-1:0] ramMem  [NADDR];
  logic [DW-1:0] ramPipe [LAT];

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < NADDR; i++) begin
        ramMem[i] <= DW'(18'h2A5A5 ^ i);
      end
      seeded <= 1'b1;
    end else if (ramWe) begin
      ramMem[ramAddr] <= ramDin;
    end
    ramPipe[0] <= ramMem[ramAddr];
    for (int i = 1; i < LAT; i++) begin
      ramPipe[i] <= ramPipe[i-1];
    end
  end

  assign ramDout = ramPipe[LAT-1];

  // Hard stop in case some wait slips past its own bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Report an expired wait as a failed comparison.
  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Drive both request channels in one go.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rv,
                               input logic [AW-1:0] ra);
    wrValid = wv;
    wrAddr  = wa;
    wrData  = wd;
    rdValid = rv;
    rdAddr  = ra;
  endtask

  // Monitor: every handed-over response is checked against the queue head.
  task automatic monitorLoop();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rstN && rspValid && rspReady) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected response: actual 0x%0h required none", rspData);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_data", 32'(rspData), 32'(e));
        end
      end
    end
  endtask

  // Offer one write until it is accepted; the reference memory is updated on
  // acceptance.
  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    applyStimulus(1'b1, a, d, 1'b0, '0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wrReady) begin
        refMem[a] = d;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    wrValid = 1'b0;
    if (!done) timeoutFail("write accept");
  endtask

  // Offer one read until it is accepted; its expected data is queued on
  // acceptance. stalls counts the cycles it had to wait.
  task automatic doRead(input logic [AW-1:0] a, output int stalls);
    bit done = 1'b0;
    stalls = 0;
    applyStimulus(1'b0, '0, '0, 1'b1, a);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rdReady) begin
        expQ.push_back(refMem[a]);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    rdValid = 1'b0;
    if (!done) timeoutFail("read accept");
  endtask

  // Wait until every queued response has been seen.
  task automatic drain();
    for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
      @(negedge clk);
    end
    if (expQ.size() != 0) timeoutFail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    int wcnt;
    int rcnt;
    int k;
    int runLen;
    int seen;
    bit done;

    fork
      monitorLoop();
    join_none

    // Reset with both requests already pending: nothing may be granted.
    rstN     = 1'b0;
    rspReady = 1'b0;
    applyStimulus(1'b1, 5'd9, 18'h3FFFF, 1'b1, 5'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset status {we,wr_rdy,rd_rdy,done,rsp_v}",
                {27'd0, ramWe, wrReady, rdReady, initDone, rspValid}, 32'd0);

    // Clear sweep: one zero write per cycle to addresses 0..31.
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < NADDR; i++) begin
      @(negedge clk);
      checkOutput($sformatf("init addr %0d", i), 32'(ramAddr), 32'(i));
      checkOutput($sformatf("init status %0d", i),
                  {28'd0, ramWe, wrReady, rdReady, initDone}, 32'h8);
      checkOutput($sformatf("init din %0d", i), 32'(ramDin), 32'd0);
      if (i == NADDR - 1) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    end
    @(negedge clk);
    checkOutput("init_done after sweep", 32'(initDone), 32'd1);
    for (int i = 0; i < NADDR; i++) refMem[i] = '0;

    // Cleared location reads back as zero.
    @(posedge clk);
    #1;
    rspReady = 1'b1;
    doRead(5'd7, stalls);
    drain();

    // Write then read the same address on the next cycle; response latency.
    doWrite(5'd3, 18'h155);
    doRead(5'd3, stalls);
    @(negedge clk);
    checkOutput("rsp_valid t+1", 32'(rspValid), 32'd0);
    @(negedge clk);
    checkOutput("rsp_valid t+2", 32'(rspValid), 32'd0);
    @(negedge clk);
    checkOutput("rsp_valid t+3", 32'(rspValid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Both channels held valid: grants alternate, write first.
    wcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'd20, DW'(18'h200 + i), 1'b1, 5'd3);
      @(negedge clk);
      checkOutput($sformatf("rr grant %0d", i),
                  {30'd0, rdReady, wrReady}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (wrReady) begin
        refMem[20] = wrData;
        wcnt++;
      end
      if (rdReady) begin
        expQ.push_back(refMem[3]);
        rcnt++;
      end
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("rr writes issued", 32'(wcnt), 32'd4);
    checkOutput("rr reads issued", 32'(rcnt), 32'd4);
    drain();
    doRead(5'd20, stalls);
    drain();

    // Fill the RAM with a known pattern for the ordering tests.
    for (int a = 0; a < NADDR; a++) begin
      doWrite(AW'(a), DW'(18'h1000 + a * 7));
    end

    // Backpressure: only DEPTH reads may be outstanding.
    rspReady = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, AW'(k));
      @(negedge clk);
      if (rdReady) begin
        expQ.push_back(refMem[k]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("reads accepted under backpressure", 32'(k), 32'd4);
    checkOutput("buffer full rsp_valid", 32'(rspValid), 32'd1);
    rspReady = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (rdReady) begin
        expQ.push_back(refMem[k]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    rdValid = 1'b0;
    checkOutput("reads resume after drain", 32'(done), 32'd1);
    drain();

    // Streaming: 32 back-to-back reads give 32 back-to-back responses.
    wcnt   = 0;
    runLen = 0;
    fork
      begin
        for (int a = 0; a < NADDR; a++) begin
          doRead(AW'(a), stalls);
          wcnt += stalls;
        end
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!rspValid && w < 40) begin
          w++;
          @(negedge clk);
        end
        while (rspValid && runLen < 100) begin
          runLen++;
          @(negedge clk);
        end
      end
    join
    checkOutput("stream read stalls", 32'(wcnt), 32'd0);
    checkOutput("stream consecutive responses", 32'(runLen), 32'd32);
    drain();

    // Reset with two reads in flight and two buffered.
    rspReady = 1'b0;
    for (int a = 0; a < 4; a++) begin
      doRead(AW'(a), stalls);
    end
    checkOutput("buffered before reset", 32'(rspValid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rsp_valid during reset", 32'(rspValid), 32'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN     = 1'b1;
    rspReady = 1'b1;
    done     = 1'b0;
    seen     = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (rspValid) seen++;
      if (initDone) done = 1'b1;
    end
    checkOutput("init_done after second reset", 32'(done), 32'd1);
    for (int i = 0; i < NADDR; i++) refMem[i] = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rspValid) seen++;
    end
    checkOutput("stale responses after reset", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    doRead(5'd5, stalls);
    drain();
    checkOutput("scoreboard empty at end", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
